// File: rtl/mux_scan_sequencer.sv
// Sweeps a 4:1 bit mux through the enabled channels, settles, samples each one and
// publishes a 4-bit snapshot per sweep, single-shot or continuously.
module mux_scan_sequencer #(
    parameter int DWELL_W    = 8,
    parameter int SETTLE_CYC = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               stop,
    input  logic               continuous,
    input  logic [3:0]         ch_mask,
    input  logic [DWELL_W-1:0] dwell,
    input  logic               mux_out_in,
    output logic               MUX_en,
    output logic [1:0]         MUX_sel,
    output logic [3:0]         sample_data,
    output logic               sample_valid,
    output logic               busy
);

    localparam int SW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam logic [SW-1:0] SETTLE_LOAD = SW'(SETTLE_CYC - 1);

    typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, ADVANCE} state_t;

    state_t             state, state_nx;
    logic [3:0]         mask_q, mask_nx;
    logic [DWELL_W-1:0] dwell_q, dwell_nx;
    logic [SW-1:0]      settle_cnt, settle_nx;
    logic [DWELL_W-1:0] dwell_cnt, dwell_cnt_nx;
    logic [3:0]         shadow, shadow_nx;
    logic               stop_pending, stop_pending_nx;
    logic [1:0]         sel_nx;
    logic [3:0]         data_nx;
    logic               valid_nx;
    logic [DWELL_W-1:0] dwell_last;
    logic [2:0]         nxt;

    function automatic logic [1:0] lowest_bit(input logic [3:0] m);
        lowest_bit = 2'd0;
        for (int i = 3; i >= 0; i--)
            if (m[i]) lowest_bit = 2'(i);
    endfunction

    // {found, index} of the lowest set mask bit strictly above s
    function automatic logic [2:0] next_above(input logic [3:0] m, input logic [1:0] s);
        next_above = 3'b000;
        for (int i = 3; i >= 0; i--)
            if (m[i] && (i > int'(s))) next_above = {1'b1, 2'(i)};
    endfunction

    // A dwell of 0 behaves as a single sample cycle
    assign dwell_last = (dwell_q == '0) ? '0 : dwell_q - DWELL_W'(1);
    assign nxt        = next_above(mask_q, MUX_sel);

    always_comb begin
        state_nx        = state;
        mask_nx         = mask_q;
        dwell_nx        = dwell_q;
        settle_nx       = settle_cnt;
        dwell_cnt_nx    = dwell_cnt;
        shadow_nx       = shadow;
        stop_pending_nx = stop_pending;
        sel_nx          = MUX_sel;
        data_nx         = sample_data;
        valid_nx        = 1'b0;

        if (stop && (state != IDLE)) stop_pending_nx = 1'b1;

        case (state)
            IDLE: begin
                if (start && (ch_mask != 4'b0000)) begin
                    mask_nx   = ch_mask;
                    dwell_nx  = dwell;
                    shadow_nx = 4'b0000;
                    sel_nx    = lowest_bit(ch_mask);
                    settle_nx = SETTLE_LOAD;
                    state_nx  = SETTLE;
                end
            end
            SETTLE: begin
                if (settle_cnt == '0) begin
                    dwell_cnt_nx = dwell_last;
                    state_nx     = SAMPLE;
                end else begin
                    settle_nx = settle_cnt - SW'(1);
                end
            end
            SAMPLE: begin
                if (dwell_cnt == '0) begin
                    shadow_nx[MUX_sel] = mux_out_in;
                    state_nx           = ADVANCE;
                end else begin
                    dwell_cnt_nx = dwell_cnt - DWELL_W'(1);
                end
            end
            ADVANCE: begin
                if (nxt[2]) begin
                    sel_nx    = nxt[1:0];
                    settle_nx = SETTLE_LOAD;
                    state_nx  = SETTLE;
                end else begin
                    data_nx  = shadow;
                    valid_nx = 1'b1;
                    // A stop landing on the final ADVANCE still ends the run here
                    if (continuous && !stop_pending && !stop) begin
                        mask_nx   = ch_mask;
                        dwell_nx  = dwell;
                        shadow_nx = 4'b0000;
                        if (ch_mask != 4'b0000) begin
                            sel_nx    = lowest_bit(ch_mask);
                            settle_nx = SETTLE_LOAD;
                            state_nx  = SETTLE;
                        end else begin
                            state_nx = IDLE;
                        end
                    end else begin
                        stop_pending_nx = 1'b0;
                        state_nx        = IDLE;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            mask_q       <= 4'b0000;
            dwell_q      <= '0;
            settle_cnt   <= '0;
            dwell_cnt    <= '0;
            shadow       <= 4'b0000;
            stop_pending <= 1'b0;
            MUX_en       <= 1'b0;
            MUX_sel      <= 2'd0;
            sample_data  <= 4'b0000;
            sample_valid <= 1'b0;
            busy         <= 1'b0;
        end else begin
            state        <= state_nx;
            mask_q       <= mask_nx;
            dwell_q      <= dwell_nx;
            settle_cnt   <= settle_nx;
            dwell_cnt    <= dwell_cnt_nx;
            shadow       <= shadow_nx;
            stop_pending <= stop_pending_nx;
            MUX_en       <= (state_nx != IDLE);
            MUX_sel      <= sel_nx;
            sample_data  <= data_nx;
            sample_valid <= valid_nx;
            busy         <= (state_nx != IDLE);
        end
    end

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Self-checking bench: vector table plus scoreboard of expected snapshots and arrival cycles.
module tb_mux_scan_sequencer;

    logic       clk = 1'b0;
    logic       rst, start, stop, continuous;
    logic [3:0] ch_mask;
    logic [7:0] dwell;
    logic       mux_out_in;
    logic       MUX_en;
    logic [1:0] MUX_sel;
    logic [3:0] sample_data;
    logic       sample_valid;
    logic       busy;
    logic [3:0] pattern;

    mux_scan_sequencer #(.DWELL_W(8), .SETTLE_CYC(2)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .continuous(continuous),
        .ch_mask(ch_mask), .dwell(dwell), .mux_out_in(mux_out_in),
        .MUX_en(MUX_en), .MUX_sel(MUX_sel), .sample_data(sample_data),
        .sample_valid(sample_valid), .busy(busy)
    );

    always #5 clk = ~clk;
    assign mux_out_in = pattern[MUX_sel];

    typedef struct {logic [3:0] data; int cyc;} obs_t;
    typedef struct {logic [3:0] mask; logic [7:0] dwell; logic [3:0] pat; logic [3:0] exp_data; int exp_lat;} vec_t;

    int   cyc = 0;
    obs_t obs_q[$];
    obs_t exp_q[$];
    int   visited[$];
    int   rd = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    logic prev_en = 1'b0;
    logic [1:0] prev_sel = 2'd0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst) begin
            if (sample_valid) obs_q.push_back('{sample_data, cyc});
            if (MUX_en && (!prev_en || MUX_sel != prev_sel)) visited.push_back(int'(MUX_sel));
        end
        prev_en  = MUX_en;
        prev_sel = MUX_sel;
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Drive a start pulse; returns the cycle count seen just after the capturing edge
    task automatic kick(input logic [3:0] m, input logic [7:0] d, input logic c,
                        input logic [3:0] p, output int k0);
        @(negedge clk);
        ch_mask = m; dwell = d; continuous = c; pattern = p; start = 1'b1;
        k0 = cyc + 1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic drain();
        int   t;
        obs_t e;
        t = 0;
        while ((obs_q.size() - rd) < exp_q.size() && t < 400) begin
            @(negedge clk);
            t++;
        end
        repeat (20) @(negedge clk);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("valid_seen", int'(rd < obs_q.size()), 1);
            if (rd < obs_q.size()) begin
                chk("sample_data", int'(obs_q[rd].data), int'(e.data));
                chk("valid_cycle", obs_q[rd].cyc, e.cyc);
                rd++;
            end
        end
        chk("extra_valid", obs_q.size() - rd, 0);
        rd = obs_q.size();
    endtask

    task automatic chk_visits(input logic [3:0] m, input int base);
        int exp_v[$];
        for (int i = 0; i < 4; i++) if (m[i]) exp_v.push_back(i);
        chk("visit_count", visited.size() - base, exp_v.size());
        for (int i = 0; i < exp_v.size(); i++)
            if (base + i < visited.size()) chk("visit_sel", visited[base + i], exp_v[i]);
    endtask

    vec_t vecs[5];

    initial begin
        int k0, vb;
        vecs[0] = '{4'b1111, 8'd1, 4'b1010, 4'b1010, 16};
        vecs[1] = '{4'b0101, 8'd3, 4'b1111, 4'b0101, 12};
        vecs[2] = '{4'b0000, 8'd2, 4'b1111, 4'b0000, 0};
        vecs[3] = '{4'b1000, 8'd0, 4'b1000, 4'b1000, 4};
        vecs[4] = '{4'b0110, 8'd2, 4'b0101, 4'b0100, 10};

        rst = 1'b1; start = 1'b0; stop = 1'b0; continuous = 1'b0;
        ch_mask = 4'b0; dwell = 8'd0; pattern = 4'b0;
        repeat (3) @(negedge clk);
        chk("rst_MUX_en", int'(MUX_en), 0);
        chk("rst_MUX_sel", int'(MUX_sel), 0);
        chk("rst_sample_data", int'(sample_data), 0);
        chk("rst_sample_valid", int'(sample_valid), 0);
        chk("rst_busy", int'(busy), 0);
        rst = 1'b0;

        for (int v = 0; v < 5; v++) begin
            vb = visited.size();
            kick(vecs[v].mask, vecs[v].dwell, 1'b0, vecs[v].pat, k0);
            if (vecs[v].mask != 4'b0) begin
                chk("busy_running", int'(busy), 1);
                exp_q.push_back('{vecs[v].exp_data, k0 + vecs[v].exp_lat});
            end else begin
                chk("busy_zero_mask", int'(busy), 0);
                chk("en_zero_mask", int'(MUX_en), 0);
            end
            drain();
            chk_visits(vecs[v].mask, vb);
            chk("busy_after", int'(busy), 0);
            chk("en_after", int'(MUX_en), 0);
        end

        // stop in IDLE must be ignored: continuous run still needs a second sweep
        @(negedge clk); stop = 1'b1; @(negedge clk); stop = 1'b0;
        kick(4'b0011, 8'd0, 1'b1, 4'b0010, k0);
        exp_q.push_back('{4'b0010, k0 + 8});
        exp_q.push_back('{4'b0010, k0 + 16});
        while (cyc < k0 + 11) @(negedge clk);
        stop = 1'b1; @(negedge clk); stop = 1'b0;
        drain();
        chk("busy_after_stop", int'(busy), 0);

        // stop coinciding with the end-of-sweep ADVANCE cycle
        kick(4'b0001, 8'd1, 1'b1, 4'b0001, k0);
        exp_q.push_back('{4'b0001, k0 + 4});
        while (cyc < k0 + 3) @(negedge clk);
        stop = 1'b1; @(negedge clk); stop = 1'b0;
        drain();
        chk("busy_after_stop_adv", int'(busy), 0);
        continuous = 1'b0;

        // restart attempt and mask change mid-sweep are ignored
        vb = visited.size();
        kick(4'b0011, 8'd1, 1'b0, 4'b1111, k0);
        exp_q.push_back('{4'b0011, k0 + 8});
        repeat (2) @(negedge clk);
        ch_mask = 4'b1100; start = 1'b1; @(negedge clk); start = 1'b0;
        drain();
        chk_visits(4'b0011, vb);

        // reset during SAMPLE of channel 2 aborts and clears the snapshot
        chk("pre_rst_data", int'(sample_data), 3);
        kick(4'b1111, 8'd4, 1'b0, 4'b1111, k0);
        while (cyc < k0 + 17) @(negedge clk);
        chk("mid_sel", int'(MUX_sel), 2);
        chk("mid_en", int'(MUX_en), 1);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_MUX_en", int'(MUX_en), 0);
        chk("abort_MUX_sel", int'(MUX_sel), 0);
        chk("abort_data", int'(sample_data), 0);
        chk("abort_busy", int'(busy), 0);
        rst = 1'b0;
        drain();
        chk("idle_after_abort", int'(busy), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
